// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
// Round-robin scheduler sharing one UART transmitter among NUM_REQ clients.
// Each grant produces a two-byte frame: header (HDR_BASE | id), then payload.
//
// Ports:
//   i_Clk          system clock
//   i_Rst          asynchronous active-high reset
//   i_req          per-requester request, held until o_ack
//   i_req_data     payload bytes, requester k on [8k+7:8k]
//   o_ack          one-cycle one-hot grant pulse (payload captured)
//   o_tx_start     one-cycle start strobe to the transmitter
//   o_tx_data      byte to the transmitter, held until the next load
//   i_tx_busy      transmitter busy flag
//   o_active       high while a frame is in progress
//   o_cur_id       id of the frame in progress
//   o_timeout_err  sticky busy-rise timeout flag
module uart_tx_scheduler #(
  parameter int          NUM_REQ      = 4,
  parameter logic [7:0]  HDR_BASE     = 8'hA0,
  parameter int          BUSY_TIMEOUT = 16,
  localparam int         IDW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [8*NUM_REQ-1:0] i_req_data,
  output logic [NUM_REQ-1:0]   o_ack,
  output logic                 o_tx_start,
  output logic [7:0]           o_tx_data,
  input  logic                 i_tx_busy,
  output logic                 o_active,
  output logic [IDW-1:0]       o_cur_id,
  output logic                 o_timeout_err
);

  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_START,
    S_WAIT_HI,
    S_WAIT_LO,
    S_NEXT
  } state_t;

  state_t               r_state,    r_state_n;
  logic [IDW-1:0]       r_rr_ptr,   r_rr_ptr_n;
  logic [IDW-1:0]       r_id,       r_id_n;
  logic [7:0]           r_payload,  r_payload_n;
  logic                 r_byte_sel, r_byte_sel_n;
  logic [CW-1:0]        r_cnt,      r_cnt_n;
  logic [NUM_REQ-1:0]   r_ack,      r_ack_n;
  logic                 r_tx_start, r_tx_start_n;
  logic [7:0]           r_tx_data,  r_tx_data_n;
  logic                 r_active,   r_active_n;
  logic [IDW-1:0]       r_cur_id,   r_cur_id_n;
  logic                 r_err,      r_err_n;

  logic                 w_found;
  logic [IDW-1:0]       w_win;
  logic [7:0]           w_hdr;

  // Rotating priority scan: first set request at or after the pointer wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      int unsigned idx;
      idx = (32'(r_rr_ptr) + i) % NUM_REQ;
      if (!w_found && i_req[IDW'(idx)]) begin
        w_found = 1'b1;
        w_win   = IDW'(idx);
      end
    end
  end

  assign w_hdr = HDR_BASE | {{(8-IDW){1'b0}}, r_id};

  // The start strobe is registered, so it appears in the first WAIT_HI cycle
  // and the busy-rise timeout window starts counting from the strobe itself.
  always_comb begin
    r_state_n    = r_state;
    r_rr_ptr_n   = r_rr_ptr;
    r_id_n       = r_id;
    r_payload_n  = r_payload;
    r_byte_sel_n = r_byte_sel;
    r_cnt_n      = r_cnt;
    r_ack_n      = '0;
    r_tx_start_n = 1'b0;
    r_tx_data_n  = r_tx_data;
    r_active_n   = r_active;
    r_cur_id_n   = r_cur_id;
    r_err_n      = r_err;

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          r_id_n      = w_win;
          r_payload_n = i_req_data[{w_win, 3'b000} +: 8];
          r_ack_n     = NUM_REQ'(1) << w_win;
          r_rr_ptr_n  = (w_win == IDW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
          r_active_n  = 1'b1;
          r_cur_id_n  = w_win;
          r_state_n   = S_GRANT;
        end
      end
      S_GRANT: begin
        r_tx_data_n  = w_hdr;
        r_byte_sel_n = 1'b0;
        if (!i_tx_busy) r_state_n = S_START;
      end
      S_START: begin
        r_tx_start_n = 1'b1;
        r_cnt_n      = '0;
        r_state_n    = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (i_tx_busy) begin
          r_state_n = S_WAIT_LO;
        end else if (r_cnt == CW'(BUSY_TIMEOUT - 1)) begin
          r_err_n    = 1'b1;
          r_active_n = 1'b0;
          r_state_n  = S_IDLE;
        end else begin
          r_cnt_n = r_cnt + 1'b1;
        end
      end
      S_WAIT_LO: begin
        if (!i_tx_busy) r_state_n = S_NEXT;
      end
      S_NEXT: begin
        if (!r_byte_sel) begin
          r_tx_data_n  = r_payload;
          r_byte_sel_n = 1'b1;
          r_state_n    = S_START;
        end else begin
          r_active_n = 1'b0;
          r_state_n  = S_IDLE;
        end
      end
      default: r_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_id       <= '0;
      r_payload  <= '0;
      r_byte_sel <= 1'b0;
      r_cnt      <= '0;
      r_ack      <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_active   <= 1'b0;
      r_cur_id   <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= r_state_n;
      r_rr_ptr   <= r_rr_ptr_n;
      r_id       <= r_id_n;
      r_payload  <= r_payload_n;
      r_byte_sel <= r_byte_sel_n;
      r_cnt      <= r_cnt_n;
      r_ack      <= r_ack_n;
      r_tx_start <= r_tx_start_n;
      r_tx_data  <= r_tx_data_n;
      r_active   <= r_active_n;
      r_cur_id   <= r_cur_id_n;
      r_err      <= r_err_n;
    end
  end

  assign o_ack         = r_ack;
  assign o_tx_start    = r_tx_start;
  assign o_tx_data     = r_tx_data;
  assign o_active      = r_active;
  assign o_cur_id      = r_cur_id;
  assign o_timeout_err = r_err;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler
// Directed and randomized checks of uart_tx_scheduler against a frame-level
// round-robin model and a simple transmitter model.
module tb_uart_tx_scheduler;

  localparam int NUM_REQ = 4;
  localparam int IDW     = 2;

  logic                 i_Clk = 1'b0;
  logic                 i_Rst = 1'b1;
  logic [NUM_REQ-1:0]   i_req = '0;
  logic [8*NUM_REQ-1:0] i_req_data = '0;
  logic [NUM_REQ-1:0]   o_ack;
  logic                 o_tx_start;
  logic [7:0]           o_tx_data;
  logic                 i_tx_busy = 1'b0;
  logic                 o_active;
  logic [IDW-1:0]       o_cur_id;
  logic                 o_timeout_err;

  uart_tx_scheduler #(.NUM_REQ(NUM_REQ), .HDR_BASE(8'hA0), .BUSY_TIMEOUT(16)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_req(i_req), .i_req_data(i_req_data),
    .o_ack(o_ack), .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
    .i_tx_busy(i_tx_busy), .o_active(o_active), .o_cur_id(o_cur_id),
    .o_timeout_err(o_timeout_err)
  );

  always #5 i_Clk = ~i_Clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int err_cyc = -1;
  int bad_start = 0;

  // transmitter model state
  logic tx_busy_m = 1'b0;
  logic busy_force = 1'b0;
  logic tx_dead = 1'b0;
  logic raise_next = 1'b0;
  int   tx_len = 4;
  int   tx_left = 0;
  logic hold_req = 1'b0;

  int   ack_q[$];
  int   ack_cyc_q[$];
  int   byte_q[$];
  int   start_cyc_q[$];
  int   exp_ack[$];
  int   exp_byte[$];
  int   m_ptr = 0;
  logic [7:0] pay [NUM_REQ];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: transmitter model update plus output monitors, sampled 1 after the edge.
  task automatic tick();
    @(posedge i_Clk);
    #1;
    cyc++;
    if (tx_left > 0) begin
      tx_left--;
      if (tx_left == 0) tx_busy_m = 1'b0;
    end
    if (raise_next) begin
      raise_next = 1'b0;
      tx_busy_m  = 1'b1;
      tx_left    = tx_len;
    end
    i_tx_busy = tx_busy_m | busy_force;
    if (o_tx_start === 1'b1) begin
      byte_q.push_back(int'(o_tx_data));
      start_cyc_q.push_back(cyc);
      if (i_tx_busy) bad_start++;
      if (!tx_dead) raise_next = 1'b1;
    end
    if (o_ack !== '0) begin
      int id;
      id = 0;
      for (int k = 0; k < NUM_REQ; k++) if (o_ack[k]) id = k;
      check("ack_onehot", 32'($onehot(o_ack)), 32'd1);
      check("ack_cur_id", 32'(o_cur_id), 32'(id));
      check("ack_active", 32'(o_active), 32'd1);
      ack_q.push_back(id);
      ack_cyc_q.push_back(cyc);
      if (!hold_req) i_req[id] = 1'b0;
    end
    if (o_timeout_err === 1'b1 && err_cyc < 0) err_cyc = cyc;
  endtask

  task automatic set_pay(input int k, input logic [7:0] v);
    pay[k] = v;
    i_req_data[k*8 +: 8] = v;
  endtask

  task automatic clear_capture();
    ack_q.delete(); ack_cyc_q.delete(); byte_q.delete(); start_cyc_q.delete();
    exp_ack.delete(); exp_byte.delete();
  endtask

  // Round-robin rule: n grants, each the first requester at or after the pointer.
  task automatic expect_grants(input logic [NUM_REQ-1:0] mask, input int n, input bit drop);
    logic [NUM_REQ-1:0] m;
    m = mask;
    for (int g = 0; g < n; g++) begin
      bit done;
      done = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
        int k;
        k = (m_ptr + i) % NUM_REQ;
        if (!done && m[k]) begin
          done = 1;
          exp_ack.push_back(k);
          exp_byte.push_back(8'hA0 + k);
          exp_byte.push_back(int'(pay[k]));
          m_ptr = (k + 1) % NUM_REQ;
          if (drop) m[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_acks(input int n, input int budget);
    int c;
    c = 0;
    while (ack_q.size() < n && c < budget) begin tick(); c++; end
    check("wait_ack_expired", 32'(c >= budget), 32'd0);
  endtask

  task automatic wait_done(input int n, input int budget);
    int c;
    c = 0;
    while (!(ack_q.size() >= n && o_active === 1'b0 && !i_tx_busy) && c < budget) begin
      tick(); c++;
    end
    check("wait_done_expired", 32'(c >= budget), 32'd0);
  endtask

  task automatic wait_starts(input int n, input int budget);
    int c;
    c = 0;
    while (start_cyc_q.size() < n && c < budget) begin tick(); c++; end
    check("wait_start_expired", 32'(c >= budget), 32'd0);
  endtask

  task automatic check_queues(input string tag);
    check({tag, "_nack"}, 32'(ack_q.size()), 32'(exp_ack.size()));
    check({tag, "_nbyte"}, 32'(byte_q.size()), 32'(exp_byte.size()));
    for (int i = 0; i < exp_ack.size() && i < ack_q.size(); i++)
      check({tag, "_ack"}, 32'(ack_q[i]), 32'(exp_ack[i]));
    for (int i = 0; i < exp_byte.size() && i < byte_q.size(); i++)
      check({tag, "_byte"}, 32'(byte_q[i]), 32'(exp_byte[i]));
  endtask

  task automatic do_reset();
    i_Rst = 1'b1;
    i_req = '0;
    tick(); tick();
    i_Rst = 1'b0;
    m_ptr = 0;
  endtask

  initial begin
    for (int k = 0; k < NUM_REQ; k++) set_pay(k, 8'h00);

    // reset values
    tick(); tick();
    check("rst_ack", 32'(o_ack), 32'd0);
    check("rst_start", 32'(o_tx_start), 32'd0);
    check("rst_data", 32'(o_tx_data), 32'd0);
    check("rst_active", 32'(o_active), 32'd0);
    check("rst_cur_id", 32'(o_cur_id), 32'd0);
    check("rst_err", 32'(o_timeout_err), 32'd0);
    i_Rst = 1'b0;
    tick();

    // single request, latency from ack to header strobe
    clear_capture();
    tx_len = 10;
    set_pay(2, 8'h5A);
    expect_grants(4'b0100, 1, 1);
    i_req = 4'b0100;
    wait_done(1, 200);
    check_queues("single");
    check("single_latency", 32'(start_cyc_q.size() > 0 ? start_cyc_q[0] - ack_cyc_q[0] : -1), 32'd2);

    // all four requesting continuously
    do_reset();
    clear_capture();
    tx_len = 3;
    for (int k = 0; k < NUM_REQ; k++) set_pay(k, 8'h10 + 8'(k));
    expect_grants(4'b1111, 5, 0);
    hold_req = 1'b1;
    i_req = 4'b1111;
    wait_acks(5, 400);
    i_req = '0;
    hold_req = 1'b0;
    wait_done(5, 200);
    check_queues("rr_all");

    // transmitter busy at grant holds off the header strobe
    clear_capture();
    set_pay(1, 8'hC3);
    expect_grants(4'b0010, 1, 1);
    i_req = 4'b0010;
    wait_acks(1, 50);
    busy_force = 1'b1;
    i_tx_busy = 1'b1;
    repeat (20) tick();
    check("busy_hold_nostart", 32'(start_cyc_q.size()), 32'd0);
    busy_force = 1'b0;
    wait_done(1, 200);
    check_queues("busy_hold");

    // busy never rises: timeout aborts the frame
    clear_capture();
    err_cyc = -1;
    tx_dead = 1'b1;
    set_pay(3, 8'h77);
    expect_grants(4'b1000, 1, 1);
    void'(exp_byte.pop_back());
    i_req = 4'b1000;
    wait_done(1, 200);
    check_queues("tmo");
    check("tmo_err", 32'(o_timeout_err), 32'd1);
    check("tmo_delay", 32'(start_cyc_q.size() > 0 ? err_cyc - start_cyc_q[0] : -1), 32'd16);
    tx_dead = 1'b0;
    clear_capture();
    set_pay(0, 8'h3C);
    expect_grants(4'b0001, 1, 1);
    i_req = 4'b0001;
    wait_done(1, 200);
    check_queues("after_tmo");
    check("tmo_sticky", 32'(o_timeout_err), 32'd1);

    // asynchronous reset during the payload byte
    clear_capture();
    tx_len = 6;
    set_pay(1, 8'h99);
    i_req = 4'b0010;
    wait_acks(1, 50);
    i_req = i_req | 4'b1001;
    wait_starts(2, 100);
    tick(); tick(); tick();
    #3;
    i_Rst = 1'b1;
    #1;
    check("arst_ack", 32'(o_ack), 32'd0);
    check("arst_start", 32'(o_tx_start), 32'd0);
    check("arst_data", 32'(o_tx_data), 32'd0);
    check("arst_active", 32'(o_active), 32'd0);
    check("arst_cur_id", 32'(o_cur_id), 32'd0);
    check("arst_err", 32'(o_timeout_err), 32'd0);
    tick();
    i_Rst = 1'b0;
    clear_capture();
    m_ptr = 0;
    expect_grants(4'b1001, 2, 1);
    wait_done(2, 300);
    check_queues("arst_regrant");

    // requester 1 withdraws before its turn; requester 3 is served
    clear_capture();
    tx_len = 2;
    expect_grants(4'b0001, 1, 1);
    expect_grants(4'b1000, 1, 1);
    i_req = 4'b0001;
    wait_acks(1, 50);
    i_req = i_req | 4'b1010;
    wait_starts(2, 100);
    i_req[1] = 1'b0;
    wait_done(2, 200);
    check_queues("withdraw");

    // randomized simultaneous request sets
    for (int r = 0; r < 8; r++) begin
      logic [NUM_REQ-1:0] mask;
      int n;
      mask = NUM_REQ'($urandom_range(1, 15));
      n = $countones(mask);
      for (int k = 0; k < NUM_REQ; k++) set_pay(k, 8'($urandom));
      tx_len = $urandom_range(1, 5);
      clear_capture();
      expect_grants(mask, n, 1);
      i_req = mask;
      wait_done(n, 400);
      check_queues("rand");
    end

    check("no_start_while_busy", 32'(bad_start), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Round-robin scheduler that shares the single UART serial transmitter among NUM_REQ independent requesters. Each granted request is sent as a two-byte frame: a header byte (HDR_BASE | requester id), then the requester's payload byte. The block sits between the client logic and the transmit side of the serial wrapper. It drives the transmitter's start strobe and data byte, and follows the transmitter's busy flag.

Parameters:
NUM_REQ, 4, number of requesters (2..8); ID width IDW = clog2(NUM_REQ)
HDR_BASE, 8'hA0, header byte base; header = HDR_BASE | id (id occupies low IDW bits; HDR_BASE low IDW bits must be 0)
BUSY_TIMEOUT, 16, max cycles to wait for i_tx_busy to rise after a start pulse

Ports:
i_Clk  in  1  system clock
i_Rst  in  1  reset, asynchronous, active-high
i_req  in  NUM_REQ  per-requester request; held high until o_ack
i_req_data  in  8*NUM_REQ  payload bytes; requester k uses bits [8k+7:8k]; stable while i_req[k] is high
o_ack  out  NUM_REQ  one-cycle one-hot pulse; payload captured
o_tx_start  out  1  one-cycle start strobe to the transmitter
o_tx_data  out  8  byte to the transmitter; valid during o_tx_start and held until the next load
i_tx_busy  in  1  transmitter busy flag
o_active  out  1  high while a frame is in progress
o_cur_id  out  IDW  id of the frame in progress
o_timeout_err  out  1  sticky; set on busy-rise timeout; cleared only by reset

Behaviour:
- Clocking and reset: one clock (i_Clk); reset i_Rst is asynchronous and active-high.
- Reset values: o_ack=0, o_tx_start=0, o_tx_data=8'h00, o_active=0, o_cur_id=0, o_timeout_err=0, state=IDLE, rr_ptr=0.
- States: IDLE, GRANT, START, WAIT_HI, WAIT_LO, NEXT.
- IDLE:
  - Scan i_req starting at rr_ptr, wrapping modulo NUM_REQ; the first set bit wins.
  - If any request is set: latch the winner's id and payload into internal registers, pulse o_ack[id] for one cycle, and go to GRANT.
  - Set rr_ptr = (id+1) mod NUM_REQ.
  - Set o_active=1 and o_cur_id=id.
- GRANT: o_tx_data <= HDR_BASE|id, byte_sel=0. Go to START on the next cycle only if i_tx_busy=0; otherwise stay in GRANT.
- START: assert o_tx_start for exactly one cycle, clear the timeout counter, then go to WAIT_HI.
- WAIT_HI:
  - If i_tx_busy=1: go to WAIT_LO.
  - Else increment the counter. When the count reaches BUSY_TIMEOUT: set o_timeout_err and abort the frame (go to IDLE, o_active=0, payload dropped).
- WAIT_LO: stay while i_tx_busy=1; on i_tx_busy=0, go to NEXT.
- NEXT:
  - If byte_sel=0: o_tx_data <= latched payload, byte_sel=1, go to START.
  - If byte_sel=1: go to IDLE and clear o_active.
- Latency:
  - Request seen in IDLE → o_ack on the next edge.
  - Header start pulse 2 cycles after o_ack, provided the transmitter is idle.
  - Minimum idle gap between frames: 1 cycle in IDLE.
- o_tx_start is never asserted while i_tx_busy=1 was sampled in the same cycle for the header, and never more than once per byte.
- Simultaneous requests: round-robin only. Requester k is granted at most once per NUM_REQ grants while others are contending.
- A requester whose i_req drops before o_ack is simply not granted; no error.
- A new request from the same requester, raised the cycle after its o_ack, is eligible at the next IDLE but is ordered behind the pointer.
- i_req changes during a frame have no effect on the frame in progress; the payload is already latched.
- Reset mid-frame: all state clears immediately and o_tx_start drops. The serializer may still finish its current byte; the scheduler does not track it.
- i_tx_busy glitching low during WAIT_LO is treated as completion; no filtering.

Test Plan:
1. Single request: i_req=4'b0100, data[23:16]=8'h5A, transmitter model raises busy 1 cycle after start for 10 cycles → o_ack=4'b0100 once; bytes 8'hA2 then 8'h5A; exactly 2 start pulses; o_active then returns to 0.
2. All four requesting continuously (payloads 8'h10, 8'h11, 8'h12, 8'h13) after reset → grant order 0,1,2,3,0; frames A0 10, A1 11, A2 12, A3 13, A0 10.
3. i_tx_busy held high at grant for 20 cycles → header start pulse occurs only after busy falls, exactly once.
4. Busy never rises after start → after 16 cycles in WAIT_HI, o_timeout_err=1, o_active=0, no payload start; the next request is still served and o_timeout_err stays 1.
5. Assert i_Rst asynchronously in WAIT_LO of the payload byte → all outputs return to reset values within the same cycle; the pending request is re-granted after release, with the pointer back at 0.
6. Requester 1 drops i_req one cycle before the arbiter reaches it, while requester 3 is high → requester 3 is granted, header 8'hA3, and no ack is issued to requester 1.
